cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 116 +++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory-burst adaptor: splits write-backs into beats and assembles fills.
// Optional macro CACHELINE_ADAPTOR_ALIGN_EN zeroes address_o[4:0].
module cacheline_adaptor #(
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned BURST_W = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int unsigned BURSTS = LINE_W / BURST_W;
   localparam int unsigned CNT_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        addr_q;
   logic [LINE_W-1:0]  line_q;
   logic               last_beat;

   assign last_beat = resp_i && (cnt == CNT_W'(BURSTS - 1));

   // Next-state logic; read_i has priority over write_i
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (read_i)
               state_next = READ;
            else if (write_i)
               state_next = WRITE;
         end
         READ:    if (last_beat) state_next = DONE;
         WRITE:   if (last_beat) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; strobes are registered from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         read_o  <= 1'b0;
         write_o <= 1'b0;
         resp_o  <= 1'b0;
      end else begin
         state   <= state_next;
         read_o  <= (state_next == READ);
         write_o <= (state_next == WRITE);
         resp_o  <= (state_next == DONE);
      end
   end

   // Request latching, beat counter and fill-line assembly
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         addr_q <= '0;
         line_q <= '0;
         line_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (read_i) begin
                  addr_q <= address_i;
                  cnt    <= '0;
               end else if (write_i) begin
                  addr_q <= address_i;
                  line_q <= line_i;
                  cnt    <= '0;
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[BURST_W*cnt +: BURST_W] <= burst_i;
                  cnt                            <= cnt + CNT_W'(1);
               end
            end
            WRITE: begin
               if (resp_i)
                  cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Write-back beat selected directly by the counter
   always_comb begin
      burst_o = '0;
      if (state == WRITE)
         burst_o = line_q[BURST_W*cnt +: BURST_W];
   end

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
   assign address_o = {addr_q[31:5], 5'b0};
`else
   assign address_o = addr_q;
`endif

endmodule
